// File: rtl/knight_move_sequencer.sv
// Knight move generator: walks the eight knight directions through an external
// registered scanner and accumulates move/capture masks, done 9 cycles after start.
module knight_move_sequencer #(
  parameter int COLOR_BIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  square,
  input  logic        side,
  output logic [5:0]  scan_position,
  output logic [2:0]  scan_direction,
  input  logic [3:0]  scan_nearest_piece,
  output logic        busy,
  output logic        done,
  output logic [63:0] move_mask,
  output logic [63:0] capture_mask,
  output logic [3:0]  move_count
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t       state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [5:0]   sq_q, sq_d;
  logic         side_q, side_d;
  logic         pipe_vld_q, pipe_vld_d;
  logic [5:0]   pipe_tgt_q, pipe_tgt_d;
  logic [63:0]  move_mask_q, move_mask_d;
  logic [63:0]  capture_mask_q, capture_mask_d;
  logic [3:0]   move_count_q, move_count_d;

  logic [2:0]        row, col;
  logic              dir_ok;
  logic signed [6:0] dir_off;
  logic signed [6:0] tgt;
  logic              take, cap;

  assign row = sq_q[5:3];
  assign col = sq_q[2:0];

  // Each direction's board-edge gate is derived from its own row/col displacement,
  // so an accepted target is always the genuine knight square.
  always_comb begin
    dir_ok  = 1'b0;
    dir_off = '0;
    case (cnt_q)
      3'd0: begin dir_ok = (row >= 3'd2) && (col >= 3'd1); dir_off = -7'sd17; end
      3'd1: begin dir_ok = (row >= 3'd1) && (col >= 3'd2); dir_off = -7'sd10; end
      3'd2: begin dir_ok = (row <= 3'd6) && (col >= 3'd2); dir_off =  7'sd6;  end
      3'd3: begin dir_ok = (row <= 3'd5) && (col >= 3'd1); dir_off =  7'sd15; end
      3'd4: begin dir_ok = (row <= 3'd5) && (col <= 3'd6); dir_off =  7'sd17; end
      3'd5: begin dir_ok = (row <= 3'd6) && (col <= 3'd5); dir_off =  7'sd10; end
      3'd6: begin dir_ok = (row >= 3'd1) && (col <= 3'd5); dir_off = -7'sd6;  end
      default: begin dir_ok = (row >= 3'd2) && (col <= 3'd6); dir_off = -7'sd15; end
    endcase
    tgt = $signed({1'b0, sq_q}) + dir_off;
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    sq_d           = sq_q;
    side_d         = side_q;
    move_mask_d    = move_mask_q;
    capture_mask_d = capture_mask_q;
    move_count_d   = move_count_q;
    take           = 1'b0;
    cap            = 1'b0;

    // Scanner result lags its request by one cycle; the pipe carries the matching target.
    pipe_vld_d = (state_q == SCAN) && dir_ok && !tgt[6];
    pipe_tgt_d = tgt[5:0];

    if (pipe_vld_q) begin
      if (scan_nearest_piece == 4'd0) begin
        take = 1'b1;
      end else if (scan_nearest_piece[COLOR_BIT] != side_q) begin
        take = 1'b1;
        cap  = 1'b1;
      end
    end
    if (take) begin
      move_mask_d[pipe_tgt_q] = 1'b1;
      if (move_count_q < 4'd8) move_count_d = move_count_q + 4'd1;
    end
    if (cap) capture_mask_d[pipe_tgt_q] = 1'b1;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d        = SCAN;
          cnt_d          = 3'd0;
          sq_d           = square;
          side_d         = side;
          move_mask_d    = '0;
          capture_mask_d = '0;
          move_count_d   = '0;
        end
      end
      SCAN: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = DRAIN;
      end
      DRAIN:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      sq_q           <= '0;
      side_q         <= 1'b0;
      pipe_vld_q     <= 1'b0;
      pipe_tgt_q     <= '0;
      move_mask_q    <= '0;
      capture_mask_q <= '0;
      move_count_q   <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      sq_q           <= sq_d;
      side_q         <= side_d;
      pipe_vld_q     <= pipe_vld_d;
      pipe_tgt_q     <= pipe_tgt_d;
      move_mask_q    <= move_mask_d;
      capture_mask_q <= capture_mask_d;
      move_count_q   <= move_count_d;
    end
  end

  assign scan_position  = sq_q;
  assign scan_direction = (state_q == SCAN) ? cnt_q : 3'd0;
  assign busy           = (state_q == SCAN) || (state_q == DRAIN);
  assign done           = (state_q == DONE);
  assign move_mask      = move_mask_q;
  assign capture_mask   = capture_mask_q;
  assign move_count     = move_count_q;

endmodule

// File: tb/tb_knight_move_sequencer.sv
// Bench for knight_move_sequencer: board/scanner model plus a row/col knight reference.
module tb_knight_move_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, side;
  logic [5:0]  square;
  logic [5:0]  scan_position;
  logic [2:0]  scan_direction;
  logic [3:0]  scan_nearest_piece;
  logic        busy, done;
  logic [63:0] move_mask, capture_mask;
  logic [3:0]  move_count;

  int errors = 0;
  int checks = 0;

  logic [3:0] board [64];
  int dr_t [8] = '{-2, -1, 1, 2, 2, 1, -1, -2};
  int dc_t [8] = '{-1, -2, -2, -1, 1, 2, 2, 1};

  knight_move_sequencer #(.COLOR_BIT(3)) dut (
    .clk(clk), .reset(reset), .start(start), .square(square), .side(side),
    .scan_position(scan_position), .scan_direction(scan_direction),
    .scan_nearest_piece(scan_nearest_piece), .busy(busy), .done(done),
    .move_mask(move_mask), .capture_mask(capture_mask), .move_count(move_count)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] scan_lookup(input logic [5:0] pos, input logic [2:0] d);
    int r, c;
    r = int'(pos[5:3]) + dr_t[d];
    c = int'(pos[2:0]) + dc_t[d];
    if (r < 0 || r > 7 || c < 0 || c > 7) return 4'd0;
    return board[r * 8 + c];
  endfunction

  // Registered scanner: one cycle from request to piece code
  always @(posedge clk) scan_nearest_piece <= scan_lookup(scan_position, scan_direction);

  function automatic void model(input int sq, input bit sd,
                                output logic [63:0] mv, output logic [63:0] cp, output int cnt);
    int r, c, t;
    logic [3:0] p;
    mv = '0;
    cp = '0;
    for (int d = 0; d < 8; d++) begin
      r = sq / 8 + dr_t[d];
      c = sq % 8 + dc_t[d];
      if (r >= 0 && r <= 7 && c >= 0 && c <= 7) begin
        t = r * 8 + c;
        p = board[t];
        if (p == 4'd0) mv[t] = 1'b1;
        else if (p[3] != sd) begin
          mv[t] = 1'b1;
          cp[t] = 1'b1;
        end
      end
    end
    cnt = $countones(mv);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_board();
    for (int i = 0; i < 64; i++) board[i] = 4'd0;
  endtask

  task automatic random_board();
    for (int i = 0; i < 64; i++)
      board[i] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
  endtask

  task automatic run_one(input int sq, input bit sd, input bit noise);
    logic [63:0] em, ec;
    int en;
    model(sq, sd, em, ec, en);
    start = 1'b1; square = 6'(sq); side = sd;
    step();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("scan_cycle", {busy, done, scan_direction, scan_position},
          {1'b1, 1'b0, 3'(k), 6'(sq)});
      if (noise) begin
        start = 1'($urandom); square = 6'($urandom); side = 1'($urandom);
      end
      step();
    end
    chk("drain", {busy, done, scan_position}, {1'b1, 1'b0, 6'(sq)});
    step();
    chk("done_pulse", {busy, done, move_count}, {1'b1 ^ 1'b1, 1'b1, 4'(en)});
    chk("move_mask", move_mask, em);
    chk("capture_mask", capture_mask, ec);
    step();
    start = 1'b0;
    chk("after_done", {busy, done}, 2'b00);
    chk("hold_mask", move_mask, em);
  endtask

  initial begin
    logic [63:0] em, ec;
    int en, cyc, hsq, seen;
    bit hsd;

    reset = 1'b1; start = 1'b0; square = '0; side = 1'b0;
    clear_board();
    step(); step();
    chk("reset_ctl", {busy, done, scan_direction, scan_position, move_count}, '0);
    chk("reset_masks", move_mask | capture_mask, '0);
    reset = 1'b0;
    step();

    // Corner, centre, captures and far-corner cases with known answers
    run_one(0, 1'b0, 1'b0);
    chk("sq0_const", {move_mask, 4'(move_count)} >> 4, 64'h0000_0000_0002_0400);
    chk("sq0_count", move_count, 4'd2);
    run_one(27, 1'b0, 1'b0);
    chk("sq27_const", move_mask, 64'h0000_1422_0022_1400);
    chk("sq27_count", move_count, 4'd8);
    board[44] = 4'b1010;
    board[10] = 4'b0010;
    run_one(27, 1'b0, 1'b0);
    chk("cap_move_const", move_mask, 64'h0000_1422_0022_1000);
    chk("cap_capt_const", capture_mask, 64'h0000_1000_0000_0000);
    chk("cap_count", move_count, 4'd7);
    clear_board();
    run_one(63, 1'b1, 1'b0);
    chk("sq63_const", move_mask, 64'h0020_4000_0000_0000);

    // Random boards, squares and sides, with ignored start/square noise mid-run
    for (int n = 0; n < 24; n++) begin
      random_board();
      run_one(int'($urandom_range(0, 63)), 1'($urandom), 1'(n % 2));
    end

    // start held high: one done per round, masks cleared on every acceptance
    hsq = int'($urandom_range(0, 63));
    hsd = 1'($urandom);
    random_board();
    start = 1'b1; square = 6'(hsq); side = hsd;
    for (int r = 0; r < 3; r++) begin
      cyc = 0;
      while (!busy && cyc < 15) begin step(); cyc++; end
      chk("held_accept", {busy, move_count, |move_mask, |capture_mask}, {1'b1, 4'd0, 1'b0, 1'b0});
      model(hsq, hsd, em, ec, en);
      cyc = 0;
      while (!done && cyc < 15) begin step(); cyc++; end
      chk("held_done", {done, move_count}, {1'b1, 4'(en)});
      chk("held_mask", move_mask, em);
      chk("held_capt", capture_mask, ec);
      random_board();
      step();
      chk("held_single_pulse", done, 1'b0);
    end
    start = 1'b0;
    step(); step();

    // Reset during the 4th SCAN cycle aborts with no done, then a new run completes
    random_board();
    start = 1'b1; square = 6'd27; side = 1'b0;
    step();
    start = 1'b0;
    step(); step(); step();
    chk("pre_abort_scan", {busy, scan_direction}, {1'b1, 3'd3});
    reset = 1'b1; start = 1'b1;
    step();
    chk("abort_ctl", {busy, done, scan_direction, scan_position, move_count}, '0);
    chk("abort_masks", move_mask | capture_mask, '0);
    reset = 1'b0; start = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) seen++;
      step();
    end
    chk("abort_quiet", seen, 0);
    run_one(27, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
